rf_wb_sched: RTL and testbench
==============================

# rf_wb_sched

Writeback scheduler for the 2-way superscalar core's integer register file. It accepts up to two writeback results per cycle from lanes 0 and 1, where lane 0 is older. It buffers them in program order and drains them through one register-file write port, one per cycle. It also publishes a per-register pending-write vector, which issue logic uses to stall RAW hazards.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `XLEN`, 64: data width.
- `AW`, 5: register address width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `wb0_valid`, in, 1: lane 0 writeback request.
- `wb0_rd`, in, AW: lane 0 destination register.
- `wb0_data`, in, XLEN: lane 0 result.
- `wb1_valid`, in, 1: lane 1 writeback request (younger).
- `wb1_rd`, in, AW: lane 1 destination register.
- `wb1_data`, in, XLEN: lane 1 result.
- `wb_ready`, out, 1: the queue can accept two entries this cycle.
- `rf_wen`, out, 1: register-file write enable.
- `rf_waddr`, out, AW: register-file write address.
- `rf_wdata`, out, XLEN: register-file write data.
- `busy`, out, 2**AW: bit r is set while a write to xr is queued.
- `count`, out, $clog2(DEPTH)+1: current number of occupied entries.

## Operation
- Handshake: a lane's request is accepted at a rising edge only when its `valid` and `wb_ready` are both high. If `valid` is high while `wb_ready` is low, nothing is accepted; upstream holds the request stable.
- `wb_ready` = (DEPTH − count) ≥ 2. It is computed from the registered count only. A pop in the same cycle does not raise it.
- Enqueue order when both lanes are accepted: lane 0 first, then lane 1.
- An accepted request with rd = 0 is discarded: nothing is enqueued and `busy` is unchanged.
- Drain:
  - While count > 0: `rf_wen` = 1, and `rf_waddr`/`rf_wdata` show the head entry.
  - The head pops at every rising edge while count > 0.
  - When empty: `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0.
- Occupancy: count_next = count + pushes (0–2) − pop (0/1). Simultaneous push and pop is legal at any fill level allowed by `wb_ready`.
- Pointers are modulo DEPTH and wrap silently. An explicit count distinguishes full from empty.
- `busy[r]` = OR over all valid entries of (entry.rd == r). It is combinational from queue state. `busy[0]` is always 0.
- Reset (including mid-operation):
  - Queue is flushed; pending writes are lost.
  - Outputs: count = 0, `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `busy` = 0, `wb_ready` = 1.

## Timing
- Latency: a request accepted at edge t drives `rf_wen` during cycle t→t+1 if it is at the head. The register file writes it at edge t+1.
- A pair accepted into an empty queue: lane 0 writes at t+1, lane 1 at t+2.
- Throughput: sustained one write per cycle; burst acceptance of two per cycle until full.
- `busy[r]` rises in the cycle after acceptance. It falls in the cycle after the last queued write to r pops.

## Configuration
- `WB_COALESCE_EN` defined:
  - Condition: both lanes accepted in the same cycle with equal nonzero rd.
  - Only lane 1 is enqueued; lane 0 is dropped as a dead WAW write.
- `WB_COALESCE_EN` undefined:
  - Both entries are enqueued in order.
  - The register file ends holding the lane 1 value after two writes.

## Structure
- Shared package `rf_pkg`:
  - Constants `XLEN`, `REG_AW`, `NREGS`.
  - `typedef struct packed { logic [REG_AW-1:0] rd; logic [XLEN-1:0] data; } wb_req_t`.
- Sub-module `wb_fifo`: DEPTH-entry circular buffer with dual push and single pop. It exposes the entry array and valid bits so the top level can derive `busy`.
- The top level holds acceptance, x0 filtering, coalescing and the busy decode.

## Test plan
- Single write: after reset, lane 0 sends rd=5, data=0x1234 → next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `busy[5]`=1. One cycle later `rf_wen`=0 and `busy`=0.
- Pair ordering: lane 0 sends x3=7 and lane 1 sends x4=9 → writes x3=7, then x4=9 on consecutive cycles; count goes 2→1→0.
- Backpressure (DEPTH=4):
  - Stimulus: hold both lanes valid with distinct rd for three cycles.
  - Required: `wb_ready` drops to 0 when count=3; no request is lost; all writes emerge in order.
- x0 filter: lane 0 rd=0 and lane 1 rd=10, data=0xFFF → a single write of x10=0xFFF; `busy[0]` is never set.
- Same rd:
  - Stimulus: lane 0 x21=1 and lane 1 x21=6.
  - With `WB_COALESCE_EN`: one write, x21=6.
  - Without it: x21=1, then x21=6.
- Reset mid-drain: assert `rst` with count=3 → `rf_wen` and `busy` go to 0 immediately; `wb_ready`=1; no further writes after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request type used by the
// writeback scheduler and its benches.
package rf_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREGS    = 2 ** REG_AW;
    localparam int unsigned WB_LANES = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Number of entries pushed for a given pair of lane accepts.
    function automatic logic [1:0] push_count(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/rf_wb_sched_fifo.sv
// wb_fifo: DEPTH-entry circular buffer with two ordered push slots and one pop.
// Exposes entry storage and per-entry valid bits for pending-write decode.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = REG_AW + XLEN,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                push_n_i,
    input  logic [W-1:0]              slot0_i,
    input  logic [W-1:0]              slot1_i,
    input  logic                      pop_i,
    output logic [W-1:0]              head_o,
    output logic [CW-1:0]             count_o,
    output logic [DEPTH-1:0][W-1:0]   entries_o,
    output logic [DEPTH-1:0]          valid_o
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_q, wr_d;
    logic [PW-1:0]           rd_q, rd_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        mem_d   = mem_q;
        if (push_n_i != 2'd0) begin
            mem_d[wr_q] = slot0_i;
        end
        if (push_n_i == 2'd2) begin
            mem_d[wr_q + PW'(1)] = slot1_i;
        end
        // Pointers are plain modulo-DEPTH counters; wraparound is implicit.
        wr_d    = wr_q + PW'(push_n_i);
        rd_d    = rd_q + PW'(pop_ok);
        count_d = count_q + CW'(push_n_i) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        valid_o = '0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - rd_q;
            valid_o[i] = {1'b0, off} < count_q;
        end
    end

    assign head_o    = mem_q[rd_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: buffers up to two writebacks per cycle and drains them through a
// single register-file write port. Optional macro WB_COALESCE_EN drops lane 0
// when both lanes target the same nonzero register in one cycle.
module rf_wb_sched
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned AW    = rf_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb0_valid,
    input  logic [AW-1:0]             wb0_rd,
    input  logic [XLEN-1:0]           wb0_data,
    input  logic                      wb1_valid,
    input  logic [AW-1:0]             wb1_rd,
    input  logic [XLEN-1:0]           wb1_data,
    output logic                      wb_ready,
    output logic                      rf_wen,
    output logic [AW-1:0]             rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [2**AW-1:0]          busy,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned W  = AW + XLEN;

    logic [W-1:0]             e0, e1, slot0, head;
    logic                     acc0, acc1;
    logic [1:0]               push_n;
    logic [CW-1:0]            fifo_count;
    logic [DEPTH-1:0][W-1:0]  entries;
    logic [DEPTH-1:0]         valid;

    assign e0 = {wb0_rd, wb0_data};
    assign e1 = {wb1_rd, wb1_data};

    // Ready looks only at registered occupancy so a same-cycle pop never helps.
    assign wb_ready = fifo_count <= CW'(DEPTH - WB_LANES);

    always_comb begin
        acc0 = wb0_valid && wb_ready && (wb0_rd != '0);
        acc1 = wb1_valid && wb_ready && (wb1_rd != '0);
`ifdef WB_COALESCE_EN
        if (acc0 && acc1 && (wb0_rd == wb1_rd)) begin
            acc0 = 1'b0;
        end
`endif
        push_n = push_count(acc0, acc1);
        slot0  = acc0 ? e0 : e1;
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_n_i  (push_n),
        .slot0_i   (slot0),
        .slot1_i   (e1),
        .pop_i     (rf_wen),
        .head_o    (head),
        .count_o   (fifo_count),
        .entries_o (entries),
        .valid_o   (valid)
    );

    assign count    = fifo_count;
    assign rf_wen   = fifo_count != '0;
    assign rf_waddr = rf_wen ? head[W-1:XLEN] : '0;
    assign rf_wdata = rf_wen ? head[XLEN-1:0] : '0;

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                busy[entries[i][W-1:XLEN]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference of the writeback rules.
module tb_rf_wb_sched;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb0_valid, wb1_valid;
    logic [4:0]       wb0_rd, wb1_rd;
    logic [63:0]      wb0_data, wb1_data;
    logic             wb_ready, rf_wen;
    logic [4:0]       rf_waddr;
    logic [63:0]      rf_wdata;
    logic [31:0]      busy;
    logic [2:0]       count;

    int      checks = 0;
    int      errors = 0;
    wb_req_t q[$];
    bit      last_acc;

    rf_wb_sched #(.DEPTH(DEPTH), .XLEN(64), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .wb_ready(wb_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eb;
        eb = '0;
        foreach (q[i]) eb[q[i].rd] = 1'b1;
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".ready"}, 64'(wb_ready), 64'((DEPTH - q.size()) >= 2));
        chk({tag, ".wen"},   64'(rf_wen), 64'(q.size() > 0));
        chk({tag, ".waddr"}, 64'(rf_waddr), q.size() > 0 ? 64'(q[0].rd) : 64'd0);
        chk({tag, ".wdata"}, rf_wdata, q.size() > 0 ? q[0].data : 64'd0);
        chk({tag, ".busy"},  64'(busy), 64'(eb));
    endtask

    // Advance one clock; the model applies the acceptance/drain rules at the edge.
    task automatic step(input string tag);
        bit rdy, a0, a1;
        rdy = (DEPTH - q.size()) >= 2;
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        a0 = rdy && wb0_valid && (wb0_rd != 0);
        a1 = rdy && wb1_valid && (wb1_rd != 0);
`ifdef WB_COALESCE_EN
        if (a0 && a1 && wb0_rd == wb1_rd) a0 = 0;
`endif
        if (a0) q.push_back('{rd: wb0_rd, data: wb0_data});
        if (a1) q.push_back('{rd: wb1_rd, data: wb1_data});
        last_acc = rdy;
        #1;
        check_model(tag);
    endtask

    task automatic idle();
        wb0_valid = 0; wb1_valid = 0;
    endtask

    task automatic drive(input bit v0, input logic [4:0] r0, input logic [63:0] d0,
                         input bit v1, input logic [4:0] r1, input logic [63:0] d1);
        wb0_valid = v0; wb0_rd = r0; wb0_data = d0;
        wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
    endtask

    initial begin
        int n_acc;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check_model("reset");
        rst = 1'b0;

        // Single write
        drive(1, 5, 64'h1234, 0, 0, 0);
        step("single");
        chk("single.x5", 64'(rf_waddr), 64'd5);
        chk("single.d", rf_wdata, 64'h1234);
        chk("single.busy5", 64'(busy[5]), 64'd1);
        idle();
        step("single.drain");
        chk("single.done", 64'(rf_wen), 64'd0);

        // Pair ordering
        drive(1, 3, 7, 1, 4, 9);
        step("pair.a");
        chk("pair.cnt2", 64'(count), 64'd2);
        idle();
        step("pair.b");
        chk("pair.x4", 64'(rf_waddr), 64'd4);
        step("pair.c");

        // Backpressure: distinct rds held stable until accepted
        n_acc = 0;
        for (int c = 0; c < 20 && n_acc < 3; c++) begin
            drive(1, 5'(6 + 2 * n_acc), 64'(100 + n_acc), 1, 5'(7 + 2 * n_acc), 64'(200 + n_acc));
            step("bp");
            if (last_acc) n_acc++;
        end
        chk("bp.accepted", 64'(n_acc), 64'd3);
        idle();
        for (int c = 0; c < 6; c++) step("bp.drain");

        // x0 filter
        drive(1, 0, 64'h55, 1, 10, 64'hFFF);
        step("x0");
        chk("x0.cnt", 64'(count), 64'd1);
        idle();
        step("x0.drain");

        // Same rd on both lanes
        drive(1, 21, 1, 1, 21, 6);
        step("same");
        idle();
        step("same.b");
        step("same.c");

        // Reset mid-drain with three queued entries
        drive(1, 11, 1, 1, 12, 2);
        step("rst.fill1");
        drive(1, 13, 3, 1, 14, 4);
        step("rst.fill2");
        chk("rst.cnt3", 64'(count), 64'd3);
        idle();
        rst = 1'b1;
        #1;
        q.delete();
        check_model("rst.async");
        step("rst.hold");
        #2 rst = 1'b0;
        step("rst.after");

        // Randomized traffic; a held request stays stable until accepted
        for (int c = 0; c < 400; c++) begin
            if (!wb0_valid || last_acc) begin
                wb0_valid = ($urandom_range(0, 3) != 0);
                wb0_rd    = 5'($urandom_range(0, 7));
                wb0_data  = {$urandom, $urandom};
            end
            if (!wb1_valid || last_acc) begin
                wb1_valid = ($urandom_range(0, 3) != 0);
                wb1_rd    = 5'($urandom_range(0, 7));
                wb1_data  = {$urandom, $urandom};
            end
            step("rand");
        end
        idle();
        for (int c = 0; c < 6; c++) step("rand.drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
